multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-002 rst  in  1  asynchronous active-high reset.
REQ-003 opcode  in  6  instruction[31:26] from the instruction register; valid from DECODE onward.
REQ-004 mem_ready  in  1  memory access completes this cycle.
REQ-005 pc_write  out  1  unconditional PC load.
REQ-006 pc_write_cond  out  1  PC load qualified by ALU zero (datapath ANDs).
REQ-007 i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-008 mem_read  out  1  memory read strobe.
REQ-009 mem_write  out  1  memory write strobe.
REQ-010 ir_write  out  1  instruction register load.
REQ-011 mem_to_reg  out  1  write-back select: 0=ALUOut, 1=MDR.
REQ-012 pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-013 alu_op  out  2  to ALU control: 00=add, 01=sub, 10=use funct.
REQ-014 alu_src_a  out  1  0=PC, 1=register A.
REQ-015 alu_src_b  out  2  00=B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-016 reg_write  out  1  register file write enable.
REQ-017 reg_dst  out  1  0=rt, 1=rd.
REQ-018 illegal_op  out  1  one-cycle pulse: unsupported opcode decoded.
REQ-019 state  out  4  current state code (debug).

Function
REQ-020 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP; all outputs not listed for a state SHALL be 0.
REQ-021 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; advance to DECODE when mem_ready=1, else hold.
REQ-022 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 100011/101011 -> MEM_ADDR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, any other -> FETCH.
REQ-023 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_RD if opcode=100011, MEM_WR if 101011.
REQ-024 MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEM_WB.
REQ-025 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-026 MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-027 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB.
REQ-028 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-029 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next FETCH.
REQ-030 JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-031 With mem_ready held 1, instruction latency in cycles SHALL be lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
REQ-032 illegal_op SHALL be registered, high exactly the cycle after a DECODE with unsupported opcode (coincident with FETCH).
REQ-033 Outputs SHALL be Moore decodes of state except ir_write/pc_write in FETCH, which are qualified by mem_ready.
REQ-034 mem_read and mem_write SHALL never be 1 in the same cycle; reg_write and pc_write SHALL never both be 1 outside FETCH.
REQ-035 Unused state codes SHALL transition to FETCH next cycle with all outputs 0.

Reset
REQ-036 rst=1 SHALL force state=FETCH and illegal_op=0 immediately, asynchronously, including mid-stall in MEM_RD/MEM_WR; stalled accesses are abandoned.
REQ-037 After rst deasserts, FETCH outputs per REQ-021 SHALL apply from the first clock.

Structure
REQ-038 Package mc_ctrl_pkg SHALL hold state codes, opcode constants (R, LW, SW, BEQ, J), alu_op and alu_src_b encodings shared with ALU control.
REQ-039 One sub-module mc_ctrl_outdec (state, mem_ready -> control word) is natural; next-state logic and registers stay in the top.

Verification
REQ-040 rst pulse during MEM_RD stall -> state=FETCH same cycle, mem_read from FETCH with i_or_d=0, no reg_write.
REQ-041 opcode=100011, mem_ready=1 -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; reg_write=1 with mem_to_reg=1 in cycle 5 only.
REQ-042 opcode=101011, mem_ready low 3 cycles in MEM_WR -> mem_write=1 for 4 cycles, then FETCH.
REQ-043 opcode=000000 -> alu_op=10 in cycle 3, reg_write=1 reg_dst=1 in cycle 4; opcode=000100 -> pc_write_cond=1, alu_op=01 in cycle 3.
REQ-044 opcode=111111 -> DECODE then FETCH, illegal_op=1 for exactly one cycle, no writes.
REQ-045 mem_ready=0 in FETCH for 2 cycles -> ir_write=pc_write=0 while stalled, 1 only in completing cycle.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcodes,
// ALU control encodings and the control-word bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC     = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  // 2'b11 is not used by ALU control
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SL2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    pc_source_t pc_source;
    alu_op_t    alu_op;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_word_t;

  function automatic logic is_legal_op(logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic [1:0] pc_source;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_write;
  logic       reg_dst;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b, reg_write,
           reg_dst, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b, reg_write,
           reg_dst, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// Control-word decode of the current state. Pure Moore, except that the
// IR/PC loads in FETCH wait for the memory to return the instruction.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_word_t cw
);

  // decode state to control word; unlisted signals and unused codes stay 0
  always_comb begin
    cw = '0;
    case (state)
      ST_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        cw.alu_src_b = SRCB_IMM_SL2;
      end
      ST_MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        cw.mem_read = 1'b1;
        cw.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        cw.mem_write = 1'b1;
        cw.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_op        = ALU_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU main controller: state register, next-state logic and the
// registered illegal-opcode flag. Control outputs come from mc_ctrl_outdec.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction at PC, PC+4; wait mem_ready
// DECODE    | read regs, branch target into ALUOut
// MEM_ADDR  | effective address A + imm
// MEM_RD    | load data read; wait mem_ready
// MEM_WB    | MDR -> rt
// MEM_WR    | store data write; wait mem_ready
// EXEC      | R-type ALU operation
// R_WB      | ALUOut -> rd
// BRANCH    | compare A-B, conditional PC load
// JUMP      | PC <- jump target
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  state_t     state_q;
  logic       illegal_q;
  ctrl_word_t cw;

  // state sequencing; a reset abandons any stalled memory access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= (state_q == ST_DECODE) && !is_legal_op(bus.opcode);
      case (state_q)
        ST_FETCH:  state_q <= bus.mem_ready ? ST_DECODE : ST_FETCH;
        ST_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state_q <= ST_MEM_ADDR;
            OP_R:         state_q <= ST_EXEC;
            OP_BEQ:       state_q <= ST_BRANCH;
            OP_J:         state_q <= ST_JUMP;
            default:      state_q <= ST_FETCH;
          endcase
        end
        ST_MEM_ADDR: begin
          if (bus.opcode == OP_LW)      state_q <= ST_MEM_RD;
          else if (bus.opcode == OP_SW) state_q <= ST_MEM_WR;
          else                          state_q <= ST_FETCH;
        end
        ST_MEM_RD: state_q <= bus.mem_ready ? ST_MEM_WB : ST_MEM_RD;
        ST_MEM_WR: state_q <= bus.mem_ready ? ST_FETCH : ST_MEM_WR;
        ST_EXEC:   state_q <= ST_R_WB;
        default:   state_q <= ST_FETCH;
      endcase
    end
  end

  mc_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .cw        (cw)
  );

  assign bus.pc_write      = cw.pc_write;
  assign bus.pc_write_cond = cw.pc_write_cond;
  assign bus.i_or_d        = cw.i_or_d;
  assign bus.mem_read      = cw.mem_read;
  assign bus.mem_write     = cw.mem_write;
  assign bus.ir_write      = cw.ir_write;
  assign bus.mem_to_reg    = cw.mem_to_reg;
  assign bus.pc_source     = cw.pc_source;
  assign bus.alu_op        = cw.alu_op;
  assign bus.alu_src_a     = cw.alu_src_a;
  assign bus.alu_src_b     = cw.alu_src_b;
  assign bus.reg_write     = cw.reg_write;
  assign bus.reg_dst       = cw.reg_dst;
  assign bus.illegal_op    = illegal_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction is expanded into its
// per-cycle plan (state visited, mem_ready driven), the expected control word
// for each cycle is queued, and a negedge monitor compares against the DUT.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  localparam int P_PW = 15, P_PWC = 14, P_IOD = 13, P_MR = 12, P_MW = 11;
  localparam int P_IRW = 10, P_M2R = 9, P_PCS = 7, P_AOP = 5, P_ASA = 4;
  localparam int P_ASB = 2, P_RW = 1, P_RD = 0;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] w;
    logic        ill;
  } exp_t;

  typedef struct {
    state_t st;
    logic   rdy;
  } plan_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  multicycle_ctrl_if bus();

  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic pend_ill = 1'b0;

  logic [5:0] pre_op [8] = '{OP_LW, OP_SW, OP_R, OP_BEQ, 6'h3f, OP_J, OP_LW, OP_SW};
  int         pre_fs [8] = '{0, 0, 0, 0, 0, 0, 2, 1};
  int         pre_ms [8] = '{0, 3, 0, 0, 0, 0, 2, 0};

  // expected control word for a cycle spent in a given state
  function automatic logic [15:0] exp_word(state_t st, logic rdy);
    logic [15:0] e;
    e = '0;
    case (st)
      ST_FETCH: begin
        e[P_MR] = 1'b1; e[P_ASB +: 2] = 2'b01; e[P_PW] = rdy; e[P_IRW] = rdy;
      end
      ST_DECODE:   e[P_ASB +: 2] = 2'b11;
      ST_MEM_ADDR: begin e[P_ASA] = 1'b1; e[P_ASB +: 2] = 2'b10; end
      ST_MEM_RD:   begin e[P_MR] = 1'b1; e[P_IOD] = 1'b1; end
      ST_MEM_WB:   begin e[P_RW] = 1'b1; e[P_M2R] = 1'b1; end
      ST_MEM_WR:   begin e[P_MW] = 1'b1; e[P_IOD] = 1'b1; end
      ST_EXEC:     begin e[P_ASA] = 1'b1; e[P_AOP +: 2] = 2'b10; end
      ST_R_WB:     begin e[P_RW] = 1'b1; e[P_RD] = 1'b1; end
      ST_BRANCH: begin
        e[P_ASA] = 1'b1; e[P_AOP +: 2] = 2'b01; e[P_PWC] = 1'b1; e[P_PCS +: 2] = 2'b01;
      end
      ST_JUMP:     begin e[P_PW] = 1'b1; e[P_PCS +: 2] = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic legal(logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  // one clock of stimulus: drive inputs, queue expectation, advance
  task automatic drive_cycle(input state_t st, input logic rdy, input logic [5:0] op,
                             input logic ill);
    exp_t e;
    bus.mem_ready = rdy;
    bus.opcode    = (st == ST_FETCH) ? 6'($urandom) : op;
    e.st  = st;
    e.w   = exp_word(st, rdy);
    e.ill = ill;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // expand one instruction into its cycle plan and play it
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
    plan_t p[$];
    for (int i = 0; i < fstall; i++) p.push_back('{ST_FETCH, 1'b0});
    p.push_back('{ST_FETCH, 1'b1});
    p.push_back('{ST_DECODE, 1'($urandom)});
    case (op)
      OP_LW: begin
        p.push_back('{ST_MEM_ADDR, 1'($urandom)});
        for (int i = 0; i < mstall; i++) p.push_back('{ST_MEM_RD, 1'b0});
        p.push_back('{ST_MEM_RD, 1'b1});
        p.push_back('{ST_MEM_WB, 1'($urandom)});
      end
      OP_SW: begin
        p.push_back('{ST_MEM_ADDR, 1'($urandom)});
        for (int i = 0; i < mstall; i++) p.push_back('{ST_MEM_WR, 1'b0});
        p.push_back('{ST_MEM_WR, 1'b1});
      end
      OP_R: begin
        p.push_back('{ST_EXEC, 1'($urandom)});
        p.push_back('{ST_R_WB, 1'($urandom)});
      end
      OP_BEQ: p.push_back('{ST_BRANCH, 1'($urandom)});
      OP_J:   p.push_back('{ST_JUMP, 1'($urandom)});
      default: ;
    endcase
    foreach (p[i]) drive_cycle(p[i].st, p[i].rdy, op, (i == 0) ? pend_ill : 1'b0);
    pend_ill = !legal(op);
  endtask

  // monitor: one queued expectation per cycle
  initial begin
    exp_t        e;
    logic [15:0] gw;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        gw = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
              bus.ir_write, bus.mem_to_reg, bus.pc_source, bus.alu_op, bus.alu_src_a,
              bus.alu_src_b, bus.reg_write, bus.reg_dst};
        total_cnt++;
        if (bus.state === e.st && gw === e.w && bus.illegal_op === e.ill) pass_cnt++;
        else $display("FAIL cycle got state=%0d ctl=%04h ill=%0b exp state=%0d ctl=%04h ill=%0b t=%0t",
                      bus.state, gw, bus.illegal_op, e.st, e.w, e.ill, $time);
        if (bus.mem_read && bus.mem_write)
          $display("FAIL rd_wr_excl got both strobes high exp at most one t=%0t", $time);
      end
    end
  end

  initial begin
    logic [5:0] op;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'd0;
    #3;
    chk("reset_state", 32'(bus.state), 32'(ST_FETCH));
    chk("reset_ill", 32'(bus.illegal_op), 32'd0);
    chk("reset_rd", 32'({bus.mem_read, bus.i_or_d, bus.ir_write, bus.pc_write}), 32'b1000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_instr(pre_op[i], pre_fs[i], pre_ms[i]);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_BEQ;
        4: op = OP_J;
        default: begin
          op = 6'($urandom);
          while (legal(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    drive_cycle(ST_FETCH, 1'b0, 6'd0, pend_ill);
    @(negedge clk); @(negedge clk); #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // async reset while a load is stalled in MEM_RD
    bus.mem_ready = 1'b1; bus.opcode = OP_LW;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rd_stall_state", 32'(bus.state), 32'(ST_MEM_RD));
    #2 rst = 1'b1;
    #1;
    chk("rst_rd_state", 32'(bus.state), 32'(ST_FETCH));
    chk("rst_rd_ctl", 32'({bus.mem_read, bus.i_or_d, bus.reg_write}), 32'b100);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_fetch", 32'({bus.pc_write, bus.ir_write, bus.mem_read}), 32'b111);
    @(posedge clk); #1;
    chk("post_rst_decode", 32'(bus.state), 32'(ST_DECODE));

    // async reset clears a pending illegal_op pulse
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.opcode = 6'h3f; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("ill_decode", 32'(bus.state), 32'(ST_DECODE));
    @(posedge clk); #1;
    chk("ill_pulse", 32'({bus.illegal_op, bus.state}), 32'({1'b1, ST_FETCH}));
    #2 rst = 1'b1;
    #1;
    chk("rst_clears_ill", 32'(bus.illegal_op), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
